// File: rtl/out_fifo_dev.sv
// out_fifo_dev: CPU-written byte FIFO drained to a valid/ready byte stream,
// with status/control registers and a level interrupt when fully drained.
module out_fifo_dev #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ien_q, ien_d;
    logic          en_q, en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic full, empty, push_req, push_ok, load;
    logic unused_din;

    assign unused_din = ^din[31:8];
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign push_req   = we && (addr == 2'd0);
    assign push_ok    = push_req && !full;
    assign load       = en_q && !empty && (!tx_valid_q || tx_ready);

    // Next-state for pointers, occupancy, sticky overflow, control and output register.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        ien_d      = ien_q;
        en_d       = en_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (load) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            tx_data_d  = mem_q[rd_ptr_q];
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case ({push_ok, load})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A push into a full FIFO is lost even if a pop frees a slot this cycle.
        if (we && (addr == 2'd1)) begin
            ovf_d = 1'b0;
        end else if (push_req && full) begin
            ovf_d = 1'b1;
        end

        if (we && (addr == 2'd2)) begin
            ien_d = din[0];
            en_d  = din[1];
        end
    end

    // Control and output-register state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ien_q      <= 1'b0;
            en_q       <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ien_q      <= ien_d;
            en_q       <= en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // FIFO storage is write-only on accepted pushes and never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din[7:0];
        end
    end

    // Register read mux.
    always_comb begin
        dout = 32'h0;
        case (addr)
            2'd1:    dout = {16'h0, 8'(count_q), 4'h0, tx_valid_q, ovf_q, full, empty};
            2'd2:    dout = {30'h0, en_q, ien_q};
            default: dout = 32'h0;
        endcase
    end

    assign irq      = ien_q && empty && !tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_out_fifo_dev.sv
module tb_out_fifo_dev;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;

    out_fifo_dev #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din), .dout(dout),
        .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake seen must match the next expected byte.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            n_acc++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %h, expected none", tx_data);
            end else begin
                exp_b = sb.pop_front();
                if (tx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h, expected %h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_out);
        if (expect_out) sb.push_back(b);
        wr(2'd0, {24'h0, b});
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb.size() != 0 || tx_valid); i++) tick();
        n_tests++;
        if (sb.size() !== 0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0; we = 1'b0; addr = 2'd0; din = 32'h0; tx_ready = 1'b0;
        tick(); tick();
        n_tests++;
        if ({tx_valid, irq, tx_data} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 000", {tx_valid, irq, tx_data});
        end
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL reset_status: got %h, expected 00000001", v);
        end
        rd(2'd2, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h, expected 00000000", v);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_drain();
        logic [31:0] v;
        tx_ready = 1'b1;
        wr(2'd2, 32'h3);
        rd(2'd2, v);
        n_tests++;
        if (v !== 32'h3) begin
            n_fail++;
            $display("FAIL ctrl_read: got %h, expected 00000003", v);
        end
        push(8'hA1, 1);
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got tx_valid %b, expected 0", tx_valid);
        end
        push(8'hB2, 1);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
            n_fail++;
            $display("FAIL latency: got %b/%h, expected 1/a1", tx_valid, tx_data);
        end
        push(8'hC3, 1);
        tick();
        n_tests++;
        if (tx_data !== 8'hC3 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL last_byte: got %h irq %b, expected c3 irq 0", tx_data, irq);
        end
        tick();
        n_tests++;
        if (irq !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_drained: got irq %b valid %b, expected 1 0", irq, tx_valid);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int a0;
        tx_ready = 1'b0;
        push(8'h55, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
                n_fail++;
                $display("FAIL hold: got %b/%h, expected 1/55", tx_valid, tx_data);
            end
            tick();
        end
        a0 = n_acc;
        tx_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (n_acc - a0 !== 1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_once: got %0d accepts, expected 1", n_acc - a0);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(2'd2, 32'h1);
        for (int i = 0; i < 9; i++) push(8'(i), i < 8);
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_0806) begin
            n_fail++;
            $display("FAIL ovf_status: got %h, expected 00000806", v);
        end
        tx_ready = 1'b1;
        wr(2'd2, 32'h3);
        drain();
        tick();
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h, expected 00000005", v);
        end
        wr(2'd1, 32'h0);
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL ovf_clear: got %h, expected 00000001", v);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        tx_ready = 1'b0;
        wr(2'd2, 32'h0);
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1);
        wr(2'd2, 32'h3);
        push(8'h99, 0);
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_070C) begin
            n_fail++;
            $display("FAIL full_push_pop: got %h, expected 0000070c", v);
        end
        tx_ready = 1'b1;
        drain();
        wr(2'd1, 32'h0);
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] v;
        tx_ready = 1'b0;
        wr(2'd2, 32'h0);
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i), 0);
        wr(2'd2, 32'h3);
        tick();
        n_tests++;
        if (tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b, expected 1", tx_valid);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%h/%b, expected 0/00/0", tx_valid, tx_data, irq);
        end
        rd(2'd1, v);
        n_tests++;
        if (v !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL reset_count: got %h, expected 00000001", v);
        end
        #2 rst = 1'b1;
        tick();
        tx_ready = 1'b1;
        wr(2'd2, 32'h3);
        push(8'h7E, 1);
        drain();
        tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_after_reset: got %b, expected 1", irq);
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
